// File: rtl/college_report_reader.sv
// Reader side of the college score channel: gathers math/physics/lab scores
// into a snapshot and hands one consolidated report to the consumer.
//
// state     | meaning
// ----------+-------------------------------------------------------------
// S_COLLECT | accepting scores, filling the have-mask, no report offered
// S_REPORT  | snapshot frozen on rpt_*, waiting for the consumer handshake
module college_report_reader #(
  parameter int W         = 8,
  parameter int MAX_SCORE = 100,
  parameter int PASS_MARK = 40
) (
  input  logic           clk_i,
  input  logic           rst_i,
  input  logic           score_valid_i,
  output logic           score_ready_o,
  input  logic [1:0]     score_subj_i,
  input  logic [W-1:0]   score_data_i,
  output logic           rpt_valid_o,
  input  logic           rpt_ready_i,
  output logic [W-1:0]   rpt_math_o,
  output logic [W-1:0]   rpt_physics_o,
  output logic [W-1:0]   rpt_lab_o,
  output logic [W+1:0]   rpt_total_o,
  output logic           rpt_pass_o,
  output logic [7:0]     rpt_count_o,
  output logic           err_clamp_o,
  output logic           err_subj_o
);

  localparam logic [W-1:0] MAX_V  = W'(MAX_SCORE);
  localparam logic [W-1:0] PASS_V = W'(PASS_MARK);

  typedef enum logic {S_COLLECT, S_REPORT} state_t;

  state_t         state_q;
  logic           score_ready_q;
  logic           rpt_valid_q;
  logic [2:0]     have_q, have_d;
  logic [W-1:0]   math_q, math_d;
  logic [W-1:0]   phys_q, phys_d;
  logic [W-1:0]   lab_q, lab_d;
  logic [W-1:0]   rpt_math_q, rpt_phys_q, rpt_lab_q;
  logic [W+1:0]   rpt_total_q, total_d;
  logic           rpt_pass_q, pass_d;
  logic [7:0]     count_q;
  logic           err_clamp_q, err_subj_q;

  logic           accept;
  logic           over;
  logic [W-1:0]   clamped;

  // score_ready is a register that is high exactly in S_COLLECT
  assign accept  = score_valid_i & score_ready_q;
  assign over    = score_data_i > MAX_V;
  assign clamped = over ? MAX_V : score_data_i;

  always_comb begin
    math_d = math_q;
    phys_d = phys_q;
    lab_d  = lab_q;
    have_d = have_q;
    if (accept) begin
      case (score_subj_i)
        2'd0: begin math_d = clamped; have_d[0] = 1'b1; end
        2'd1: begin phys_d = clamped; have_d[1] = 1'b1; end
        2'd2: begin lab_d  = clamped; have_d[2] = 1'b1; end
        default: ;
      endcase
    end
    total_d = {2'b00, math_d} + {2'b00, phys_d} + {2'b00, lab_d};
    pass_d  = (math_d >= PASS_V) && (phys_d >= PASS_V) && (lab_d >= PASS_V);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q       <= S_COLLECT;
      score_ready_q <= 1'b1;
      rpt_valid_q   <= 1'b0;
      have_q        <= '0;
      math_q        <= '0;
      phys_q        <= '0;
      lab_q         <= '0;
      rpt_math_q    <= '0;
      rpt_phys_q    <= '0;
      rpt_lab_q     <= '0;
      rpt_total_q   <= '0;
      rpt_pass_q    <= 1'b0;
      count_q       <= '0;
      err_clamp_q   <= 1'b0;
      err_subj_q    <= 1'b0;
    end else begin
      case (state_q)
        S_COLLECT: begin
          math_q <= math_d;
          phys_q <= phys_d;
          lab_q  <= lab_d;
          have_q <= have_d;
          if (accept && over && (score_subj_i != 2'd3)) err_clamp_q <= 1'b1;
          if (accept && (score_subj_i == 2'd3))         err_subj_q  <= 1'b1;
          // snapshot includes the score arriving on this very edge
          if (have_d == 3'b111) begin
            state_q       <= S_REPORT;
            score_ready_q <= 1'b0;
            rpt_valid_q   <= 1'b1;
            rpt_math_q    <= math_d;
            rpt_phys_q    <= phys_d;
            rpt_lab_q     <= lab_d;
            rpt_total_q   <= total_d;
            rpt_pass_q    <= pass_d;
          end
        end
        S_REPORT: begin
          if (rpt_ready_i) begin
            state_q       <= S_COLLECT;
            score_ready_q <= 1'b1;
            rpt_valid_q   <= 1'b0;
            have_q        <= '0;
            count_q       <= count_q + 8'd1;
          end
        end
        default: begin
          state_q       <= S_COLLECT;
          score_ready_q <= 1'b1;
          rpt_valid_q   <= 1'b0;
        end
      endcase
    end
  end

  assign score_ready_o = score_ready_q;
  assign rpt_valid_o   = rpt_valid_q;
  assign rpt_math_o    = rpt_math_q;
  assign rpt_physics_o = rpt_phys_q;
  assign rpt_lab_o     = rpt_lab_q;
  assign rpt_total_o   = rpt_total_q;
  assign rpt_pass_o    = rpt_pass_q;
  assign rpt_count_o   = count_q;
  assign err_clamp_o   = err_clamp_q;
  assign err_subj_o    = err_subj_q;

endmodule

// File: tb/tb_college_report_reader.sv
// Self-checking bench for college_report_reader: directed scenarios plus
// randomized score streams compared against a simple snapshot model.
module tb_college_report_reader;

  logic       clk = 1'b0;
  logic       rst;
  logic       score_valid;
  logic       score_ready;
  logic [1:0] score_subj;
  logic [7:0] score_data;
  logic       rpt_valid;
  logic       rpt_ready;
  logic [7:0] rpt_math, rpt_physics, rpt_lab;
  logic [9:0] rpt_total;
  logic       rpt_pass;
  logic [7:0] rpt_count;
  logic       err_clamp, err_subj;

  int vectors = 0;
  int miscompares = 0;

  // reference model: slot values, received-subject mask, counters, flags
  int m_slot [3];
  bit m_have [3];
  int m_count;
  bit m_eclamp, m_esubj;

  always #5 clk = ~clk;

  college_report_reader #(.W(8), .MAX_SCORE(100), .PASS_MARK(40)) dut (
    .clk_i(clk), .rst_i(rst),
    .score_valid_i(score_valid), .score_ready_o(score_ready),
    .score_subj_i(score_subj), .score_data_i(score_data),
    .rpt_valid_o(rpt_valid), .rpt_ready_i(rpt_ready),
    .rpt_math_o(rpt_math), .rpt_physics_o(rpt_physics), .rpt_lab_o(rpt_lab),
    .rpt_total_o(rpt_total), .rpt_pass_o(rpt_pass), .rpt_count_o(rpt_count),
    .err_clamp_o(err_clamp), .err_subj_o(err_subj)
  );

  function automatic bit model_full();
    return m_have[0] && m_have[1] && m_have[2];
  endfunction

  task automatic do_reset();
    rst = 1'b1;
    score_valid = 1'b0;
    rpt_ready = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin m_slot[i] = 0; m_have[i] = 0; end
    m_count = 0; m_eclamp = 0; m_esubj = 0;
    vectors++;
    if (rpt_valid !== 1'b0 || rpt_math !== 8'd0 || rpt_physics !== 8'd0 ||
        rpt_lab !== 8'd0 || rpt_total !== 10'd0 || rpt_pass !== 1'b0 ||
        rpt_count !== 8'd0 || err_clamp !== 1'b0 || err_subj !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_outputs: valid=%0b m=%0d p=%0d l=%0d tot=%0d pass=%0b cnt=%0d ec=%0b es=%0b, required all zero",
               rpt_valid, rpt_math, rpt_physics, rpt_lab, rpt_total, rpt_pass, rpt_count, err_clamp, err_subj);
    end
    vectors++;
    if (score_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL reset_score_ready: got %0b, required 1", score_ready);
    end
  endtask

  // Offer one score, wait (bounded) for acceptance, update the model and
  // check that rpt_valid follows the final score by exactly one cycle.
  task automatic send(input logic [1:0] subj, input logic [7:0] data);
    int n = 0;
    score_valid = 1'b1;
    score_subj  = subj;
    score_data  = data;
    while (score_ready !== 1'b1 && n < 20) begin @(posedge clk); #1; n++; end
    if (n >= 20) begin
      vectors++; miscompares++;
      $display("FAIL send_timeout: score_ready never rose for subj=%0d", subj);
      score_valid = 1'b0;
      return;
    end
    @(posedge clk); #1;
    score_valid = 1'b0;
    if (subj == 2'd3) m_esubj = 1;
    else begin
      if (data > 100) m_eclamp = 1;
      m_slot[subj] = (data > 100) ? 100 : int'(data);
      m_have[subj] = 1;
    end
    vectors++;
    if (rpt_valid !== model_full()) begin
      miscompares++;
      $display("FAIL rpt_valid_after_score: got %0b, required %0b", rpt_valid, model_full());
    end
    vectors++;
    if (err_clamp !== m_eclamp || err_subj !== m_esubj) begin
      miscompares++;
      $display("FAIL err_flags: got clamp=%0b subj=%0b, required clamp=%0b subj=%0b",
               err_clamp, err_subj, m_eclamp, m_esubj);
    end
  endtask

  // Wait for the report, hold it for 'hold' cycles (optionally with a score
  // offered meanwhile), check every cycle, then complete the handshake.
  task automatic take_report(input int hold, input bit push_scores);
    int n = 0;
    int tot;
    bit pass;
    while (rpt_valid !== 1'b1 && n < 20) begin @(posedge clk); #1; n++; end
    if (n >= 20) begin
      vectors++; miscompares++;
      $display("FAIL report_timeout: rpt_valid never rose");
      return;
    end
    tot  = m_slot[0] + m_slot[1] + m_slot[2];
    pass = (m_slot[0] >= 40) && (m_slot[1] >= 40) && (m_slot[2] >= 40);
    for (int c = 0; c <= hold; c++) begin
      vectors++;
      if (rpt_valid !== 1'b1 || score_ready !== 1'b0) begin
        miscompares++;
        $display("FAIL report_handshake_state: cyc=%0d valid=%0b ready=%0b, required 1/0", c, rpt_valid, score_ready);
      end
      vectors++;
      if (rpt_math !== 8'(m_slot[0]) || rpt_physics !== 8'(m_slot[1]) || rpt_lab !== 8'(m_slot[2])) begin
        miscompares++;
        $display("FAIL report_scores: cyc=%0d got %0d/%0d/%0d, required %0d/%0d/%0d",
                 c, rpt_math, rpt_physics, rpt_lab, m_slot[0], m_slot[1], m_slot[2]);
      end
      vectors++;
      if (rpt_total !== 10'(tot) || rpt_pass !== pass || rpt_count !== 8'(m_count)) begin
        miscompares++;
        $display("FAIL report_summary: cyc=%0d got tot=%0d pass=%0b cnt=%0d, required tot=%0d pass=%0b cnt=%0d",
                 c, rpt_total, rpt_pass, rpt_count, tot, pass, m_count);
      end
      vectors++;
      if (err_clamp !== m_eclamp || err_subj !== m_esubj) begin
        miscompares++;
        $display("FAIL report_err_flags: got %0b/%0b, required %0b/%0b", err_clamp, err_subj, m_eclamp, m_esubj);
      end
      if (c < hold) begin
        if (push_scores) begin
          score_valid = 1'b1;
          score_subj  = 2'($urandom_range(0, 2));
          score_data  = 8'($urandom_range(0, 255));
        end
        @(posedge clk); #1;
      end
    end
    score_valid = 1'b0;
    rpt_ready = 1'b1;
    @(posedge clk); #1;
    rpt_ready = 1'b0;
    m_count = (m_count + 1) % 256;
    for (int i = 0; i < 3; i++) m_have[i] = 0;
    vectors++;
    if (rpt_valid !== 1'b0 || score_ready !== 1'b1 || rpt_count !== 8'(m_count)) begin
      miscompares++;
      $display("FAIL after_handshake: valid=%0b ready=%0b cnt=%0d, required 0/1/%0d",
               rpt_valid, score_ready, rpt_count, m_count);
    end
  endtask

  task automatic test_reset();
    do_reset();
  endtask

  task automatic test_basic();
    send(2'd0, 8'd85); send(2'd1, 8'd90); send(2'd2, 8'd95);
    take_report(0, 0);
  endtask

  task automatic test_order_fail();
    send(2'd2, 8'd30); send(2'd0, 8'd50); send(2'd1, 8'd60);
    take_report(1, 0);
  endtask

  task automatic test_overwrite();
    send(2'd0, 8'd85); send(2'd0, 8'd99); send(2'd1, 8'd45); send(2'd2, 8'd70);
    take_report(0, 0);
  endtask

  task automatic test_errors();
    send(2'd1, 8'd200);
    send(2'd3, 8'($urandom_range(0, 255)));
    send(2'd0, 8'd41); send(2'd2, 8'd101);
    take_report(2, 0);
    send(2'd0, 8'd10); send(2'd1, 8'd20); send(2'd2, 8'd40);
    take_report(0, 0);
  endtask

  task automatic test_backpressure();
    send(2'd0, 8'd66); send(2'd1, 8'd77); send(2'd2, 8'd88);
    take_report(5, 1);
  endtask

  task automatic test_random();
    for (int r = 0; r < 30; r++) begin
      int guard = 0;
      while (!model_full() && guard < 40) begin
        send(2'($urandom_range(0, 3)), ($urandom_range(0, 3) == 0) ? 8'($urandom_range(101, 255))
                                                                   : 8'($urandom_range(0, 100)));
        guard++;
      end
      take_report($urandom_range(0, 3), 1'($urandom_range(0, 1)));
    end
  endtask

  task automatic test_reset_mid();
    send(2'd0, 8'd70); send(2'd1, 8'd71); send(2'd2, 8'd72);
    do_reset();
    send(2'd0, 8'd77);
    do_reset();
    send(2'd1, 8'd50); send(2'd2, 8'd50);
    send(2'd0, 8'd60);
    take_report(0, 0);
  endtask

  task automatic test_wrap();
    do_reset();
    for (int r = 0; r < 256; r++) begin
      send(2'd0, 8'($urandom_range(0, 255)));
      send(2'd1, 8'($urandom_range(0, 255)));
      send(2'd2, 8'($urandom_range(0, 255)));
      take_report(0, 0);
    end
    vectors++;
    if (rpt_count !== 8'd0) begin
      miscompares++;
      $display("FAIL count_wrap: got %0d, required 0", rpt_count);
    end
  endtask

  initial begin
    rst = 1'b1; score_valid = 1'b0; score_subj = '0; score_data = '0; rpt_ready = 1'b0;
    @(posedge clk); #1;
    test_reset();
    test_basic();
    test_order_fail();
    test_overwrite();
    test_errors();
    test_backpressure();
    test_random();
    test_reset_mid();
    test_wrap();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
